eth_frame_arbiter: RTL and testbench

//   Frame-granular arbiter sharing one eth_axis_tx header+payload input between

---
 rtl/eth_frame_arbiter.sv | 153 +++++++++++++++
 tb/tb_eth_frame_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_arbiter.sv
// eth_frame_arbiter: frame-granular arbiter sharing one eth_axis_tx input.
// Define ETH_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority.
module eth_frame_arbiter #(
    parameter  int PORTS      = 2,
    parameter  int DATA_WIDTH = 8,
    localparam int SEL_W      = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            s_eth_hdr_valid,
    output logic [PORTS-1:0]            s_eth_hdr_ready,
    input  logic [PORTS*48-1:0]         s_eth_dest_mac,
    input  logic [PORTS*48-1:0]         s_eth_src_mac,
    input  logic [PORTS*16-1:0]         s_eth_type,
    input  logic [PORTS*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [PORTS-1:0]            s_eth_payload_axis_tvalid,
    input  logic [PORTS-1:0]            s_eth_payload_axis_tlast,
    input  logic [PORTS-1:0]            s_eth_payload_axis_tuser,
    output logic [PORTS-1:0]            s_eth_payload_axis_tready,
    output logic                        m_eth_hdr_valid,
    input  logic                        m_eth_hdr_ready,
    output logic [47:0]                 m_eth_dest_mac,
    output logic [47:0]                 m_eth_src_mac,
    output logic [15:0]                 m_eth_type,
    output logic [DATA_WIDTH-1:0]       m_eth_payload_axis_tdata,
    output logic                        m_eth_payload_axis_tvalid,
    output logic                        m_eth_payload_axis_tlast,
    output logic                        m_eth_payload_axis_tuser,
    input  logic                        m_eth_payload_axis_tready,
    output logic [SEL_W-1:0]            grant_index,
    output logic                        busy,
    output logic [15:0]                 frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] grant_next;
    logic [SEL_W-1:0] pick;
    logic             any_req;
    logic             hdr_fire;
    logic             last_fire;

    assign any_req = |s_eth_hdr_valid;
    assign busy    = (state != IDLE);

    assign hdr_fire = (state == HDR)
                    && s_eth_hdr_valid[grant_index]
                    && m_eth_hdr_ready;

    assign last_fire = (state == PAYLOAD)
                     && s_eth_payload_axis_tvalid[grant_index]
                     && s_eth_payload_axis_tlast[grant_index]
                     && m_eth_payload_axis_tready;

`ifdef ETH_ARB_STRICT_PRIO_EN
    // Scan downward so the lowest-index requester is the last to overwrite.
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand = '0;
        pick = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            cand = SEL_W'(i);
            if (s_eth_hdr_valid[cand]) pick = cand;
        end
    end
`else
    logic [SEL_W-1:0] last_grant;

    // Scan from farthest to nearest after last_grant; nearest wins.
    always_comb begin
        logic [SEL_W-1:0] cand;
        int               idx;
        cand = '0;
        idx  = 0;
        pick = '0;
        for (int i = PORTS; i >= 1; i--) begin
            idx  = (int'(last_grant) + i) % PORTS;
            cand = SEL_W'(idx);
            if (s_eth_hdr_valid[cand]) pick = cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SEL_W'(PORTS - 1);
        end else if (last_fire) begin
            last_grant <= grant_index;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_index <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            grant_index <= grant_next;
            if (last_fire) frame_count <= frame_count + 16'd1;
        end
    end

    always_comb begin
        state_next                = state;
        grant_next                = grant_index;
        s_eth_hdr_ready           = '0;
        s_eth_payload_axis_tready = '0;
        m_eth_hdr_valid           = 1'b0;
        m_eth_dest_mac            = '0;
        m_eth_src_mac             = '0;
        m_eth_type                = '0;
        m_eth_payload_axis_tdata  = '0;
        m_eth_payload_axis_tvalid = 1'b0;
        m_eth_payload_axis_tlast  = 1'b0;
        m_eth_payload_axis_tuser  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant_next = pick;
                    state_next = HDR;
                end
            end
            HDR: begin
                m_eth_hdr_valid = s_eth_hdr_valid[grant_index];
                m_eth_dest_mac  = s_eth_dest_mac[grant_index*48 +: 48];
                m_eth_src_mac   = s_eth_src_mac[grant_index*48 +: 48];
                m_eth_type      = s_eth_type[grant_index*16 +: 16];
                s_eth_hdr_ready[grant_index] = m_eth_hdr_ready;
                if (hdr_fire) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                m_eth_payload_axis_tdata =
                    s_eth_payload_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
                m_eth_payload_axis_tvalid = s_eth_payload_axis_tvalid[grant_index];
                m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast[grant_index];
                m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser[grant_index];
                s_eth_payload_axis_tready[grant_index] = m_eth_payload_axis_tready;
                if (last_fire) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_frame_arbiter.sv
// Bench for eth_frame_arbiter: per-port frame sources, scoreboarded outputs,
// a vector table of arbitration scenarios and hand-written reset/wrap cases.
`timescale 1ns/1ps
module tb_eth_frame_arbiter;

    localparam int P  = 2;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P-1:0]    s_eth_hdr_valid;
    logic [P-1:0]    s_eth_hdr_ready;
    logic [P*48-1:0] s_eth_dest_mac;
    logic [P*48-1:0] s_eth_src_mac;
    logic [P*16-1:0] s_eth_type;
    logic [P*DW-1:0] s_eth_payload_axis_tdata;
    logic [P-1:0]    s_eth_payload_axis_tvalid;
    logic [P-1:0]    s_eth_payload_axis_tlast;
    logic [P-1:0]    s_eth_payload_axis_tuser;
    logic [P-1:0]    s_eth_payload_axis_tready;
    logic            m_eth_hdr_valid;
    logic            m_eth_hdr_ready;
    logic [47:0]     m_eth_dest_mac;
    logic [47:0]     m_eth_src_mac;
    logic [15:0]     m_eth_type;
    logic [DW-1:0]   m_eth_payload_axis_tdata;
    logic            m_eth_payload_axis_tvalid;
    logic            m_eth_payload_axis_tlast;
    logic            m_eth_payload_axis_tuser;
    logic            m_eth_payload_axis_tready;
    logic [0:0]      grant_index;
    logic            busy;
    logic [15:0]     frame_count;

    eth_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
        .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
        .m_eth_hdr_valid           (m_eth_hdr_valid),
        .m_eth_hdr_ready           (m_eth_hdr_ready),
        .m_eth_dest_mac            (m_eth_dest_mac),
        .m_eth_src_mac             (m_eth_src_mac),
        .m_eth_type                (m_eth_type),
        .m_eth_payload_axis_tdata  (m_eth_payload_axis_tdata),
        .m_eth_payload_axis_tvalid (m_eth_payload_axis_tvalid),
        .m_eth_payload_axis_tlast  (m_eth_payload_axis_tlast),
        .m_eth_payload_axis_tuser  (m_eth_payload_axis_tuser),
        .m_eth_payload_axis_tready (m_eth_payload_axis_tready),
        .grant_index               (grant_index),
        .busy                      (busy),
        .frame_count               (frame_count)
    );

    always #4 clk = ~clk;

    // Source queues (what each port presents) and scoreboard queues.
    logic [111:0] hdr_q   [P][$];
    logic [111:0] hdr_exp [P][$];
    logic [9:0]   drv_q   [P][$];
    logic [9:0]   exp_q   [P][$];
    int           seq_n   [P];
    int           got_order[$];
    int           beats_out = 0;
    logic [P-1:0] hdr_acc = '0;
    logic         bp = 1'b0;
    logic [P-1:0] hh;
    logic [P-1:0] dh;
    int           n_cmp = 0;
    int           n_bad = 0;

    typedef struct {
        bit do_rst;
        int n0;
        int n1;
        int len;
        bit bp;
        int n_ord;
        int ord[4];
        int cnt;
    } row_t;

    row_t rows[4];

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_port(input int p);
        logic [111:0] h;
        logic [9:0]   d;
        h = '0;
        d = '0;
        if (hdr_q[p].size() > 0) h = hdr_q[p][0];
        if (drv_q[p].size() > 0) d = drv_q[p][0];
        s_eth_hdr_valid[p]                 = (hdr_q[p].size() > 0);
        s_eth_dest_mac[p*48 +: 48]         = h[111:64];
        s_eth_src_mac[p*48 +: 48]          = h[63:16];
        s_eth_type[p*16 +: 16]             = h[15:0];
        s_eth_payload_axis_tvalid[p]       = (drv_q[p].size() > 0);
        s_eth_payload_axis_tdata[p*DW +: DW] = d[7:0];
        s_eth_payload_axis_tlast[p]        = d[8];
        s_eth_payload_axis_tuser[p]        = d[9];
    endtask

    task automatic send_frame(input int p, input int len);
        logic [111:0] h;
        logic [9:0]   d;
        logic [7:0]   s;
        logic         lst;
        seq_n[p]++;
        s = 8'(seq_n[p]);
        h = {8'hD0 + 8'(p), 32'h0, s,
             8'h02, 32'hAB00_0000, s,
             16'h0800 + 16'(p)};
        hdr_q[p].push_back(h);
        hdr_exp[p].push_back(h);
        for (int b = 0; b < len; b++) begin
            lst = (b == len - 1);
            d = {lst & (p == 1), lst, 1'(p), s[2:0], 4'(b)};
            drv_q[p].push_back(d);
            exp_q[p].push_back(d);
        end
    endtask

    task automatic flush_all();
        for (int p = 0; p < P; p++) begin
            hdr_q[p].delete();
            hdr_exp[p].delete();
            drv_q[p].delete();
            exp_q[p].delete();
            drive_port(p);
        end
    endtask

    task automatic do_reset();
        tick();
        flush_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (!busy && hdr_q[0].size() == 0 && hdr_q[1].size() == 0
                && drv_q[0].size() == 0 && drv_q[1].size() == 0)
                done = 1'b1;
        end
        if (!done) fail_now({nm, "_timeout"});
    endtask

    task automatic set_row(input int i, input bit r, input int n0,
                           input int n1, input int len, input bit b,
                           input int no, input int o0, input int o1,
                           input int o2, input int o3, input int cnt);
        rows[i].do_rst = r;
        rows[i].n0     = n0;
        rows[i].n1     = n1;
        rows[i].len    = len;
        rows[i].bp     = b;
        rows[i].n_ord  = no;
        rows[i].ord[0] = o0;
        rows[i].ord[1] = o1;
        rows[i].ord[2] = o2;
        rows[i].ord[3] = o3;
        rows[i].cnt    = cnt;
    endtask

    // Source driver: handshakes sampled mid-cycle, queues advanced after edge.
    initial begin
        s_eth_hdr_valid           = '0;
        s_eth_dest_mac            = '0;
        s_eth_src_mac             = '0;
        s_eth_type                = '0;
        s_eth_payload_axis_tdata  = '0;
        s_eth_payload_axis_tvalid = '0;
        s_eth_payload_axis_tlast  = '0;
        s_eth_payload_axis_tuser  = '0;
        m_eth_hdr_ready           = 1'b1;
        m_eth_payload_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            hh = s_eth_hdr_valid & s_eth_hdr_ready;
            dh = s_eth_payload_axis_tvalid & s_eth_payload_axis_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < P; p++) begin
                if (hh[p] && hdr_q[p].size() > 0) void'(hdr_q[p].pop_front());
                if (dh[p] && drv_q[p].size() > 0) void'(drv_q[p].pop_front());
                drive_port(p);
            end
            m_eth_payload_axis_tready = bp ? ~m_eth_payload_axis_tready : 1'b1;
        end
    end

    // Output monitor and scoreboard.
    initial begin
        logic [111:0] eh;
        logic [9:0]   eb;
        forever begin
            @(negedge clk);
            for (int p = 0; p < P; p++)
                check($sformatf("tready_p%0d", p),
                      128'(s_eth_payload_axis_tready[p]),
                      128'(hdr_acc[p] & m_eth_payload_axis_tready));
            for (int p = 0; p < P; p++) begin
                if (s_eth_hdr_valid[p] && s_eth_hdr_ready[p]) begin
                    if (hdr_exp[p].size() == 0) begin
                        fail_now($sformatf("hdr_unexpected_p%0d", p));
                    end else begin
                        eh = hdr_exp[p].pop_front();
                        check($sformatf("hdr_p%0d", p),
                              {m_eth_hdr_valid, m_eth_dest_mac,
                               m_eth_src_mac, m_eth_type},
                              {1'b1, eh});
                    end
                    got_order.push_back(p);
                    hdr_acc[p] = 1'b1;
                end
                if (s_eth_payload_axis_tvalid[p] && s_eth_payload_axis_tready[p]) begin
                    beats_out++;
                    if (exp_q[p].size() == 0) begin
                        fail_now($sformatf("beat_unexpected_p%0d", p));
                    end else begin
                        eb = exp_q[p].pop_front();
                        check($sformatf("beat_p%0d", p),
                              {m_eth_payload_axis_tvalid,
                               m_eth_payload_axis_tuser,
                               m_eth_payload_axis_tlast,
                               m_eth_payload_axis_tdata},
                              {1'b1, eb});
                        if (eb[8]) hdr_acc[p] = 1'b0;
                    end
                end
            end
            if (rst) hdr_acc = '0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        bit hit;
        seq_n[0] = 0;
        seq_n[1] = 0;

        set_row(0, 1, 0, 1, 4, 0, 1, 1, 0, 0, 0, 1);
`ifdef ETH_ARB_STRICT_PRIO_EN
        set_row(1, 1, 2, 2, 3, 0, 4, 0, 0, 1, 1, 4);
`else
        set_row(1, 1, 2, 2, 3, 0, 4, 0, 1, 0, 1, 4);
`endif
        set_row(2, 0, 1, 1, 6, 1, 2, 0, 1, 0, 0, 6);
        set_row(3, 0, 1, 1, 5, 0, 2, 0, 1, 0, 0, 8);

        do_reset();
        @(negedge clk);
        check("reset_state",
              {busy, m_eth_hdr_valid, m_eth_payload_axis_tvalid,
               s_eth_hdr_ready, s_eth_payload_axis_tready,
               grant_index, frame_count},
              '0);

        for (int r = 0; r < 4; r++) begin
            if (rows[r].do_rst) do_reset();
            bp = rows[r].bp;
            got_order.delete();
            for (int k = 0; k < rows[r].n0; k++) send_frame(0, rows[r].len);
            for (int k = 0; k < rows[r].n1; k++) send_frame(1, rows[r].len);
            wait_idle($sformatf("row%0d", r), 500);
            bp = 1'b0;
            check($sformatf("row%0d_nframes", r),
                  128'(got_order.size()), 128'(rows[r].n_ord));
            for (int k = 0; k < rows[r].n_ord; k++) begin
                if (k < got_order.size())
                    check($sformatf("row%0d_order%0d", r, k),
                          128'(got_order[k]), 128'(rows[r].ord[k]));
                else
                    fail_now($sformatf("row%0d_order%0d_missing", r, k));
            end
            check($sformatf("row%0d_frame_count", r),
                  128'(frame_count), 128'(rows[r].cnt));
            check($sformatf("row%0d_grant", r),
                  128'(grant_index), 128'(rows[r].ord[rows[r].n_ord-1]));
            check($sformatf("row%0d_busy", r), 128'(busy), 128'(0));
        end

        // Mid-frame reset: port0 served last, then port1 frame cut at beat 3.
        send_frame(0, 2);
        wait_idle("pre_rst", 100);
        b0 = beats_out;
        send_frame(1, 8);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (beats_out >= b0 + 2) hit = 1'b1;
        end
        if (!hit) fail_now("mid_frame_wait_timeout");
        tick();
        flush_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_outputs",
              {busy, m_eth_hdr_valid, m_eth_payload_axis_tvalid,
               m_eth_payload_axis_tlast, s_eth_hdr_ready,
               s_eth_payload_axis_tready, m_eth_payload_axis_tdata,
               m_eth_dest_mac},
              '0);
        check("midrst_count_grant", {frame_count, 7'd0, grant_index}, '0);
        got_order.delete();
        send_frame(1, 2);
        send_frame(0, 2);
        wait_idle("post_rst", 200);
        check("post_rst_first", 128'(got_order.size() > 0 ? got_order[0] : 9), 128'(0));
        check("post_rst_second", 128'(got_order.size() > 1 ? got_order[1] : 9), 128'(1));
        check("post_rst_count", 128'(frame_count), 128'(2));

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        tick();
        release dut.frame_count;
        @(negedge clk);
        check("preload", 128'(frame_count), 128'(16'hFFFF));
        send_frame(1, 3);
        wait_idle("wrap", 100);
        check("wrap_count", 128'(frame_count), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
